pipelined_cla_subtractor: RTL and testbench

Two-stage pipelined WIDTH-bit subtractor. Computes a − b − borrow_in with the same propagate/generate ripple-lookahead datapath as the team's CLA adders, using two's-complement addition (a + ~b + ~borrow_in). The carry is split at the half-word boundary and registered between stages. It sits behind the adder blocks in the arithmetic datapath, is fed and drained through valid/ready handshakes, and also reports borrow, signed overflow and zero flags.

---
 rtl/pipelined_cla_subtractor_if.sv | 27 ++
 rtl/pipelined_cla_subtractor.sv | 104 ++++++++++
 tb/tb_pipelined_cla_subtractor.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pipelined_cla_subtractor_if.sv
// Operand/result bundle for the two-stage CLA subtractor.
// Both sides use valid/ready: a beat moves on a cycle where valid && ready, and the sender keeps the beat stable until then.
interface pipelined_cla_subtractor_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, borrow_in, out_ready,
        input  in_ready, out_valid, diff, borrow_out, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, borrow_in, out_ready,
        output in_ready, out_valid, diff, borrow_out, overflow, zero
    );
endinterface

// File: rtl/pipelined_cla_subtractor.sv
// Two-stage subtractor: a - b - borrow_in computed as a + ~b + ~borrow_in.
// The propagate/generate carry chain is split at WIDTH/2, and the half-word carry is registered between the stages.
module pipelined_cla_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    pipelined_cla_subtractor_if.slave  bus
);
    localparam int LO = WIDTH / 2;
    localparam int HI = WIDTH - LO;

    logic          s1_valid;
    logic [LO-1:0] lo_diff_r;
    logic          lo_carry_r;
    logic [HI-1:0] a_hi_r;
    logic [HI-1:0] bi_hi_r;

    logic s2_free;
    logic s1_adv;
    logic accept;

    assign s2_free      = !bus.out_valid || bus.out_ready;
    assign s1_adv       = s1_valid && s2_free;
    assign bus.in_ready = !rst && (!s1_valid || s2_free);
    assign accept       = bus.in_valid && bus.in_ready;

    // Stage 1: lower half of a + ~b, with carry-in ~borrow_in
    logic [WIDTH-1:0] bi;
    logic [LO-1:0]    p_lo, g_lo, sum_lo;
    logic [LO:0]      c_lo;

    assign bi   = ~bus.b;
    assign p_lo = bus.a[LO-1:0] ^ bi[LO-1:0];
    assign g_lo = bus.a[LO-1:0] & bi[LO-1:0];

    always_comb begin
        c_lo    = '0;
        c_lo[0] = ~bus.borrow_in;
        for (int i = 0; i < LO; i++) begin
            c_lo[i+1] = g_lo[i] | (p_lo[i] & c_lo[i]);
        end
    end

    assign sum_lo = p_lo ^ c_lo[LO-1:0];

    // Stage 2: upper half, continuing from the registered half-word carry
    logic [HI-1:0]    p_hi, g_hi, hi_diff;
    logic [HI:0]      c_hi;
    logic [WIDTH-1:0] diff_next;
    logic             ovf_next;

    assign p_hi = a_hi_r ^ bi_hi_r;
    assign g_hi = a_hi_r & bi_hi_r;

    always_comb begin
        c_hi    = '0;
        c_hi[0] = lo_carry_r;
        for (int i = 0; i < HI; i++) begin
            c_hi[i+1] = g_hi[i] | (p_hi[i] & c_hi[i]);
        end
    end

    assign hi_diff   = p_hi ^ c_hi[HI-1:0];
    assign diff_next = {hi_diff, lo_diff_r};
    // The sign bit of b is ~bi, so a and b differ in sign exactly when a and bi agree.
    assign ovf_next  = (a_hi_r[HI-1] == bi_hi_r[HI-1]) && (hi_diff[HI-1] != a_hi_r[HI-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            lo_diff_r  <= '0;
            lo_carry_r <= 1'b0;
            a_hi_r     <= '0;
            bi_hi_r    <= '0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            lo_diff_r  <= sum_lo;
            lo_carry_r <= c_lo[LO];
            a_hi_r     <= bus.a[WIDTH-1:LO];
            bi_hi_r    <= bi[WIDTH-1:LO];
        end else if (s1_adv) begin
            s1_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.diff       <= '0;
            bus.borrow_out <= 1'b0;
            bus.overflow   <= 1'b0;
            bus.zero       <= 1'b0;
        end else if (s1_adv) begin
            bus.out_valid  <= 1'b1;
            bus.diff       <= diff_next;
            bus.borrow_out <= ~c_hi[HI];
            bus.overflow   <= ovf_next;
            bus.zero       <= (diff_next == '0);
        end else if (bus.out_ready) begin
            bus.out_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// Directed bench for pipelined_cla_subtractor: reset, hand-computed vectors, back-pressure and mid-stream reset.
module tb_pipelined_cla_subtractor;
    localparam int W  = 32;
    localparam int EW = W + 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_cla_subtractor_if #(.WIDTH(W)) bus ();
    pipelined_cla_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, borrow_out, zero, diff} from a plain wide subtraction.
    function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0]   t;
        logic [W-1:0] d;
        logic         ov;
        t  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        d  = t[W-1:0];
        ov = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
        return {ov, t[W], (d == '0), d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                            input logic [W-1:0] ed, input logic ebo, input logic eov, input logic ez);
        bus.a = a; bus.b = b; bus.borrow_in = bin;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, W'(bus.in_ready), W'(1));
        tick();
        bus.in_valid = 1'b0;
        check({tag, "_valid_early"}, W'(bus.out_valid), W'(0));
        tick();
        check({tag, "_valid"}, W'(bus.out_valid), W'(1));
        check({tag, "_diff"}, bus.diff, ed);
        check({tag, "_flags"}, W'({bus.borrow_out, bus.overflow, bus.zero}), W'({ebo, eov, ez}));
        tick();
    endtask

    int sent, recv;
    logic held_v;
    logic [EW-1:0] held, e;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.borrow_in = 1'b0; bus.out_ready = 1'b0;
        tick(); tick();
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_diff", bus.diff, '0);
        check("rst_flags", W'({bus.borrow_out, bus.overflow, bus.zero}), W'(0));
        check("rst_in_ready", W'(bus.in_ready), W'(0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", W'(bus.in_ready), W'(1));
        tick();

        directed("basic", 32'd5, 32'd3, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
        directed("wrap", 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        directed("bin_zero", 32'd7, 32'd6, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
        directed("sovf", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        directed("half_carry", 32'h0001_0000, 32'd1, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);

        // Back-pressure: 6 random beats, out_ready low for cycles 2..5.
        sent = 0; recv = 0; held_v = 1'b0; held = '0;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            bus.out_ready = !(c >= 2 && c <= 5);
            if (sent < 6) begin
                bus.in_valid = 1'b1;
                bus.a = $urandom; bus.b = $urandom; bus.borrow_in = 1'($urandom_range(0, 1));
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            check("bp_in_ready", W'(bus.in_ready), W'(!(exp_q.size() == 2 && !bus.out_ready)));
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $error("FAIL bp_unexpected observed=%0h expected=none", bus.diff);
                    end else begin
                        e = exp_q.pop_front();
                        check("bp_diff", bus.diff, e[W-1:0]);
                        check("bp_flags", W'({bus.overflow, bus.borrow_out, bus.zero}), W'(e[EW-1:W]));
                    end
                    recv++;
                    held_v = 1'b0;
                end else if (held_v) begin
                    check("bp_stall_stable", W'({bus.overflow, bus.borrow_out, bus.zero}), W'(held[EW-1:W]));
                    check("bp_stall_diff", bus.diff, held[W-1:0]);
                end else begin
                    held = {bus.overflow, bus.borrow_out, bus.zero, bus.diff};
                    held_v = 1'b1;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.a, bus.b, bus.borrow_in));
                sent++;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("bp_received", W'(recv), W'(6));
        check("bp_sent", W'(sent), W'(6));

        // Reset with two beats in flight.
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.a = 32'h1234_5678; bus.b = 32'd1; bus.borrow_in = 1'b0;
        tick();
        bus.a = 32'h0F0F_0F0F; bus.b = 32'd2;
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("mid_pre_valid", W'(bus.out_valid), W'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", W'(bus.in_ready), W'(0));
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("mid_out_valid", W'(bus.out_valid), W'(0));
        check("mid_diff", bus.diff, '0);
        check("mid_flags", W'({bus.borrow_out, bus.overflow, bus.zero}), W'(0));
        check("mid_in_ready", W'(bus.in_ready), W'(1));
        for (int k = 0; k < 4; k++) begin
            tick();
            check("mid_no_stale", W'(bus.out_valid), W'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
